multi_cycle_control: RTL
========================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- OpCode  in  6  opcode field from the instruction register; stable from DECODE onward.
- Funct  in  6  function field from the instruction register.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by the ALU Zero flag in the datapath (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  2  write-back data: 00 = ALUOut, 01 = MDR, 10 = PC.
- RegDst  out  2  destination: 00 = rt, 01 = rd, 10 = $31.
- RegWrite  out  1  register file write.
- ALUSrcA  out  2  ALU A input: 00 = PC, 01 = reg A, 10 = shamt.
- ALUSrcB  out  2  ALU B input: 00 = reg B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- ALUOp  out  4  ALU control code.
- ExtOp  out  1  immediate extension: 1 = sign, 0 = zero.
- LuOp  out  1  immediate is shifted left by 16 (lui).
- PCSource  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reg A.
- Exception  out  1  datapath loads the trap vector into PC.
- InstrDone  out  1  one-cycle pulse in the final cycle of every instruction.
- State  out  4  current state encoding, for debug.

Function
REQ-002 The FSM SHALL use these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JUMP=10, TRAP=11; encodings 12-15 SHALL go to FETCH on the next edge.
REQ-003 FETCH SHALL assert MemRead, IRWrite and PCWrite with IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=0000, PCSource=00 (PC<=PC+4); next state is DECODE.
REQ-004 DECODE SHALL drive ALUSrcA=00, ALUSrcB=11, ALUOp=0000 so that ALUOut receives the branch target, and SHALL dispatch as follows:
- lw(23), sw(2b) → MEMADR.
- R-type(00) with Funct 08 or 09 → JUMP.
- any other R-type → EXEC_R.
- 08, 09, 0c, 0a, 0b, 0f → EXEC_I.
- 04 → BRANCH.
- 02, 03 → JUMP.
- any other opcode → TRAP.
REQ-005 MEMADR SHALL drive ALUSrcA=01, ALUSrcB=10, ExtOp=1; next state is MEMRD for lw and MEMWR for sw.
REQ-006 MEMRD SHALL assert MemRead with IorD=1, then go to MEMWB; MEMWB SHALL assert RegWrite with RegDst=00 and MemtoReg=01.
REQ-007 MEMWR SHALL assert MemWrite with IorD=1.
REQ-008 EXEC_R SHALL drive ALUSrcB=00, ALUOp=0010, and ALUSrcA=10 when Funct is 00, 02 or 03, otherwise ALUSrcA=01; next state is ALUWB.
REQ-009 EXEC_I SHALL drive ALUSrcA=01, ALUSrcB=10, ExtOp=0 only for 0c, LuOp=1 only for 0f; ALUOp[2:0] SHALL be 100 for 0c, 101 for 0a/0b, 000 otherwise; next state is ALUWB.
REQ-010 In every state, ALUOp[3] SHALL equal OpCode[0] outside FETCH/DECODE, and SHALL be 0 in FETCH/DECODE.
REQ-011 ALUWB SHALL assert RegWrite with MemtoReg=00; RegDst SHALL be 01 for R-type and 00 for I-type; ALU controls SHALL hold their EXEC values.
REQ-012 BRANCH SHALL assert PCWriteCond with ALUSrcA=01, ALUSrcB=00, ALUOp=0001, PCSource=01.
REQ-013 JUMP SHALL assert PCWrite in all cases:
- j: PCSource=10.
- jal: PCSource=10, plus RegWrite with RegDst=10, MemtoReg=10.
- jr: PCSource=11.
- jalr: PCSource=11, plus RegWrite with RegDst=01, MemtoReg=10.
REQ-014 Exit states SHALL be MEMWB, MEMWR, ALUWB, BRANCH, JUMP and TRAP: each returns to FETCH and asserts InstrDone for exactly one cycle. Resulting cycle counts: lw 5; sw, R-type and I-type 4; beq, j/jal/jr/jalr 3.
REQ-015 In every state, all enables not listed for that state SHALL be 0 and selects not listed SHALL be 0.

Reset
REQ-016 While reset=1 at an edge, the next state SHALL be FETCH regardless of current state, including mid-instruction.
REQ-017 During the reset cycle, all write enables (PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite), MemRead, Exception and InstrDone SHALL be 0, and State SHALL read 0 after the edge.

Configuration
REQ-018 With ILLEGAL_OP_TRAP_EN defined, TRAP SHALL assert Exception and PCWrite for one cycle with all other enables 0.
REQ-019 Without ILLEGAL_OP_TRAP_EN, DECODE SHALL send an unknown opcode directly to FETCH, asserting InstrDone in DECODE; TRAP SHALL be unreachable and Exception SHALL be tied to 0.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then lw (OpCode=23): State sequence 0,1,2,3,4,0; MemRead in states 0 and 3; RegWrite only in state 4 with MemtoReg=01; InstrDone once.
- add (OpCode=00, Funct=20) then sll (Funct=00): 4 cycles each; ALUSrcA=01 for add and 10 for sll; ALUWB has RegDst=01.
- andi (0c), then slti (0a): EXEC_I gives ALUOp=0100/ExtOp=0 for andi and ALUOp=0101/ExtOp=1 for slti.
- beq (04), then jal (03), then jr (00/08): 3 cycles each; PCWriteCond=1 with PCSource=01; jal RegDst=10 with RegWrite; jr PCSource=11 with RegWrite=0.
- OpCode=3f: with the macro, states 0,1,11,0 and Exception=1 for one cycle; without it, states 0,1,0 with Exception=0.
- reset asserted in MEMRD: State=0 on the next edge, no RegWrite pulse; next fetch proceeds normally.

Source files
------------

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: control FSM for a multi-cycle MIPS-style datapath.
//
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   OpCode, Funct       : instruction fields. OpCode must be stable from DECODE onward.
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite
//                       : datapath enables and selects
//   MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource
//                       : datapath mux selects
//   ALUOp, ExtOp, LuOp  : ALU and immediate control
//   Exception           : load the trap vector into PC
//   InstrDone           : one-cycle pulse in the last cycle of each instruction
//   State               : current state encoding, for debug
//
// Build option: ILLEGAL_OP_TRAP_EN
//   Defined: an unknown opcode goes through TRAP, which raises Exception.
//   Undefined: DECODE retires an unknown opcode and returns to FETCH. Exception stays 0.
module multi_cycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic       ExtOp,
  output logic       LuOp,
  output logic [1:0] PCSource,
  output logic       Exception,
  output logic       InstrDone,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StTrap   = 4'd11
  } state_e;

  state_e r_state;
  state_e w_next_state;

  // Instruction classification
  logic w_is_lw, w_is_sw, w_is_r, w_is_rjump, w_is_imm, w_is_beq, w_is_j, w_shift;
  assign w_is_lw    = (OpCode == 6'h23);
  assign w_is_sw    = (OpCode == 6'h2b);
  assign w_is_r     = (OpCode == 6'h00);
  assign w_is_rjump = w_is_r && ((Funct == 6'h08) || (Funct == 6'h09));
  assign w_is_imm   = (OpCode == 6'h08) || (OpCode == 6'h09) || (OpCode == 6'h0c) ||
                      (OpCode == 6'h0a) || (OpCode == 6'h0b) || (OpCode == 6'h0f);
  assign w_is_beq   = (OpCode == 6'h04);
  assign w_is_j     = (OpCode == 6'h02) || (OpCode == 6'h03);
  // sll/srl/sra take the shift amount on ALU input A
  assign w_shift    = (Funct == 6'h00) || (Funct == 6'h02) || (Funct == 6'h03);

  // ALU controls for the execute step. ALUWB re-drives these so the result stays valid.
  logic [1:0] w_exec_src_a, w_exec_src_b;
  logic [2:0] w_exec_alu_lo;
  logic       w_exec_ext, w_exec_lu;
  assign w_exec_src_a  = (w_is_r && w_shift) ? 2'b10 : 2'b01;
  assign w_exec_src_b  = w_is_r ? 2'b00 : 2'b10;
  assign w_exec_alu_lo = w_is_r                                    ? 3'b010 :
                         (OpCode == 6'h0c)                         ? 3'b100 :
                         ((OpCode == 6'h0a) || (OpCode == 6'h0b))  ? 3'b101 : 3'b000;
  assign w_exec_ext    = !w_is_r && (OpCode != 6'h0c);
  assign w_exec_lu     = !w_is_r && (OpCode == 6'h0f);

  always_ff @(posedge clk) begin
    if (reset) r_state <= StFetch;
    else       r_state <= w_next_state;
  end

  assign State = r_state;

  always_comb begin
    w_next_state = StFetch;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    MemtoReg     = 2'b00;
    RegDst       = 2'b00;
    RegWrite     = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    // Outside FETCH/DECODE, ALUOp[3] carries OpCode[0] (the unsigned/variant bit)
    ALUOp        = {OpCode[0], 3'b000};
    ExtOp        = 1'b0;
    LuOp         = 1'b0;
    PCSource     = 2'b00;
    Exception    = 1'b0;
    InstrDone    = 1'b0;

    case (r_state)
      StFetch: begin
        MemRead      = 1'b1;
        IRWrite      = 1'b1;
        PCWrite      = 1'b1;
        ALUSrcB      = 2'b01;
        ALUOp        = 4'b0000;
        w_next_state = StDecode;
      end
      StDecode: begin
        // Precompute the branch target into ALUOut
        ALUSrcB = 2'b11;
        ALUOp   = 4'b0000;
        if (w_is_lw || w_is_sw)           w_next_state = StMemAdr;
        else if (w_is_rjump || w_is_j)    w_next_state = StJump;
        else if (w_is_r)                  w_next_state = StExecR;
        else if (w_is_imm)                w_next_state = StExecI;
        else if (w_is_beq)                w_next_state = StBranch;
        else begin
`ifdef ILLEGAL_OP_TRAP_EN
          w_next_state = StTrap;
`else
          InstrDone    = 1'b1;
          w_next_state = StFetch;
`endif
        end
      end
      StMemAdr: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        ExtOp        = 1'b1;
        w_next_state = w_is_lw ? StMemRd : StMemWr;
      end
      StMemRd: begin
        MemRead      = 1'b1;
        IorD         = 1'b1;
        w_next_state = StMemWb;
      end
      StMemWb: begin
        RegWrite  = 1'b1;
        MemtoReg  = 2'b01;
        InstrDone = 1'b1;
      end
      StMemWr: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = 1'b1;
      end
      StExecR, StExecI: begin
        ALUSrcA      = w_exec_src_a;
        ALUSrcB      = w_exec_src_b;
        ALUOp        = {OpCode[0], w_exec_alu_lo};
        ExtOp        = w_exec_ext;
        LuOp         = w_exec_lu;
        w_next_state = StAluWb;
      end
      StAluWb: begin
        ALUSrcA   = w_exec_src_a;
        ALUSrcB   = w_exec_src_b;
        ALUOp     = {OpCode[0], w_exec_alu_lo};
        ExtOp     = w_exec_ext;
        LuOp      = w_exec_lu;
        RegWrite  = 1'b1;
        RegDst    = w_is_r ? 2'b01 : 2'b00;
        InstrDone = 1'b1;
      end
      StBranch: begin
        PCWriteCond = 1'b1;
        ALUSrcA     = 2'b01;
        ALUOp       = {OpCode[0], 3'b001};
        PCSource    = 2'b01;
        InstrDone   = 1'b1;
      end
      StJump: begin
        PCWrite   = 1'b1;
        InstrDone = 1'b1;
        if (w_is_r) begin
          PCSource = 2'b11;
          if (Funct == 6'h09) begin
            RegWrite = 1'b1;
            RegDst   = 2'b01;
            MemtoReg = 2'b10;
          end
        end else begin
          PCSource = 2'b10;
          if (OpCode == 6'h03) begin
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
          end
        end
      end
`ifdef ILLEGAL_OP_TRAP_EN
      StTrap: begin
        Exception = 1'b1;
        PCWrite   = 1'b1;
        InstrDone = 1'b1;
      end
`endif
      default: w_next_state = StFetch;
    endcase

    // Suppress every side effect while reset is held, even mid-instruction
    if (reset) begin
      w_next_state = StFetch;
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      MemRead      = 1'b0;
      Exception    = 1'b0;
      InstrDone    = 1'b0;
    end
  end

endmodule
